// File: rtl/sdram_rd_pixel_fifo_if.sv
// Signal bundle between the SDRAM read bridge, the pixel FIFO and the LCD driver.
// The slave modport is the FIFO side.
interface sdram_rd_pixel_fifo_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0] bridge_readdata;
  logic              bridge_readdatavalid;
  logic              lcd_data_req;
  logic              err_clr;
  logic [DATA_W-1:0] pixel_data;
  logic [ADDR_W-1:0] source_fifo_wrusedw;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  bridge_readdata, bridge_readdatavalid, lcd_data_req, err_clr,
    output pixel_data, source_fifo_wrusedw, fifo_full, fifo_empty, overflow, underflow
  );

  modport master (
    output bridge_readdata, bridge_readdatavalid, lcd_data_req, err_clr,
    input  pixel_data, source_fifo_wrusedw, fifo_full, fifo_empty, overflow, underflow
  );
endinterface

// File: rtl/sdram_rd_pixel_fifo.sv
// 1024-word non-show-ahead FIFO between the SDRAM read bridge and the LCD pixel request,
// with a saturated fill level for burst throttling and sticky overflow/underflow flags.
module sdram_rd_pixel_fifo #(
  parameter int                DATA_W          = 16,
  parameter int                ADDR_W          = 10,
  parameter logic [DATA_W-1:0] UNDERFLOW_PIXEL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdram_rd_pixel_fifo_if.slave  bus
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_pixel;
  logic [ADDR_W-1:0] r_usedw;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_cnt_zero;
  logic              w_cnt_full;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_ovf_evt;
  logic              w_unf_evt;
  logic [ADDR_W:0]   w_count_nxt;

  assign w_cnt_zero = (r_count == '0);
  assign w_cnt_full = r_count[ADDR_W];
  assign w_rd_acc   = bus.lcd_data_req & ~w_cnt_zero;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign w_wr_acc   = bus.bridge_readdatavalid & (~w_cnt_full | w_rd_acc);
  assign w_ovf_evt  = bus.bridge_readdatavalid & ~w_wr_acc;
  assign w_unf_evt  = bus.lcd_data_req & w_cnt_zero;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)
      w_count_nxt = r_count + CNT_ONE;
    else if (w_rd_acc && !w_wr_acc)
      w_count_nxt = r_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr] <= bus.bridge_readdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pixel     <= '0;
      r_usedw     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) begin
        r_pixel  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else if (w_unf_evt) begin
        r_pixel  <= UNDERFLOW_PIXEL;
      end
      r_count <= w_count_nxt;
      // Saturate so the upstream "usedw < 512" test stays false when completely full.
      r_usedw <= w_count_nxt[ADDR_W] ? '1 : w_count_nxt[ADDR_W-1:0];
      r_full  <= w_count_nxt[ADDR_W];
      r_empty <= (w_count_nxt == '0);
      if (w_ovf_evt)
        r_overflow <= 1'b1;
      else if (bus.err_clr)
        r_overflow <= 1'b0;
      if (w_unf_evt)
        r_underflow <= 1'b1;
      else if (bus.err_clr)
        r_underflow <= 1'b0;
    end
  end

  assign bus.pixel_data          = r_pixel;
  assign bus.source_fifo_wrusedw = r_usedw;
  assign bus.fifo_full           = r_full;
  assign bus.fifo_empty          = r_empty;
  assign bus.overflow            = r_overflow;
  assign bus.underflow           = r_underflow;

endmodule

// File: tb/tb_sdram_rd_pixel_fifo.sv
// Scoreboard bench: stimulus queues the expected pixel for every request; a monitor
// pops and compares one cycle later. Fill level and flags are checked inline.
module tb_sdram_rd_pixel_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_rd_pixel_fifo_if #(.DATA_W(16), .ADDR_W(10)) bus ();

  sdram_rd_pixel_fifo #(
    .DATA_W(16), .ADDR_W(10), .UNDERFLOW_PIXEL(16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];
  logic        req_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a request seen at a rising edge has its pixel visible by the next falling edge.
  always @(posedge clk) req_seen <= bus.lcd_data_req & rst_n;

  always @(negedge clk) begin
    if (req_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pixel_unexpected: got 0x%0h with no expected entry", bus.pixel_data);
      end else begin
        chk("pixel_data", 32'(bus.pixel_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive one clock of stimulus from just after a falling edge; returns at the next one.
  task automatic step(input logic v, input logic [15:0] d, input logic r,
                      input logic clr, input logic [15:0] exp_pix);
    bus.bridge_readdatavalid = v;
    bus.bridge_readdata      = d;
    bus.lcd_data_req         = r;
    bus.err_clr              = clr;
    if (r) exp_q.push_back(exp_pix);
    @(negedge clk);
    bus.bridge_readdatavalid = 1'b0;
    bus.bridge_readdata      = 16'h0000;
    bus.lcd_data_req         = 1'b0;
    bus.err_clr              = 1'b0;
  endtask

  task automatic chk_state(input string nm, input int usedw, input logic full,
                           input logic empty);
    chk({nm, "_usedw"}, 32'(bus.source_fifo_wrusedw), 32'(usedw));
    chk({nm, "_full"},  32'(bus.fifo_full),  32'(full));
    chk({nm, "_empty"}, 32'(bus.fifo_empty), 32'(empty));
  endtask

  initial begin
    bus.bridge_readdatavalid = 1'b0;
    bus.bridge_readdata      = 16'h0000;
    bus.lcd_data_req         = 1'b0;
    bus.err_clr              = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pixel", 32'(bus.pixel_data), 32'h0);
    chk_state("rst", 0, 1'b0, 1'b1);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    chk("rst_unf", 32'(bus.underflow), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 512 writes 0x0000..0x01FF
    for (int i = 0; i < 512; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0, 16'h0);
      chk("wr512_usedw", 32'(bus.source_fifo_wrusedw), 32'(i + 1));
      chk("wr512_empty", 32'(bus.fifo_empty), 32'h0);
    end
    chk("wr512_ovf", 32'(bus.overflow), 32'h0);

    // 512 reads back
    for (int i = 0; i < 512; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 16'(i));
    @(negedge clk);
    chk_state("rd512", 0, 1'b0, 1'b1);
    chk("rd512_unf", 32'(bus.underflow), 32'h0);

    // Fill to 1024, then one dropped word
    for (int i = 0; i < 1024; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, 16'h0);
    chk_state("full", 1023, 1'b1, 1'b0);
    chk("full_ovf_pre", 32'(bus.overflow), 32'h0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0);
    chk_state("drop", 1023, 1'b1, 1'b0);
    chk("drop_ovf", 32'(bus.overflow), 32'h1);
    for (int i = 0; i < 1024; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 16'hA000 + 16'(i));
    @(negedge clk);
    chk_state("drain1024", 0, 1'b0, 1'b1);

    // 600 words, then 100 cycles of simultaneous write+read, then drain across the rd wrap
    for (int i = 0; i < 600; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 16'h0);
    chk_state("c600", 600, 1'b0, 1'b0);
    for (int j = 0; j < 100; j++) begin
      step(1'b1, 16'h2000 + 16'(j), 1'b1, 1'b0, 16'h1000 + 16'(j));
      chk("concur_usedw", 32'(bus.source_fifo_wrusedw), 32'd600);
    end
    for (int i = 100; i < 600; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 16'h1000 + 16'(i));
    for (int j = 0; j < 100; j++) step(1'b0, 16'h0, 1'b1, 1'b0, 16'h2000 + 16'(j));
    @(negedge clk);
    chk_state("wrap_drain", 0, 1'b0, 1'b1);

    // Underflow and sticky clear
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0000);
    chk("unf_set", 32'(bus.underflow), 32'h1);
    chk_state("unf", 0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0);
    chk("unf_clr", 32'(bus.underflow), 32'h0);
    chk("ovf_clr", 32'(bus.overflow), 32'h0);
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0000);
    chk("unf_evt_wins", 32'(bus.underflow), 32'h1);

    // Write and read 0x5A5A so pixel_data is non-zero before the reset test
    step(1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h5A5A);
    @(negedge clk);
    chk("pre_rst_pixel", 32'(bus.pixel_data), 32'h5A5A);

    // Mid-stream asynchronous reset
    for (int i = 0; i < 150; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0, 16'h0);
    chk("mid_usedw", 32'(bus.source_fifo_wrusedw), 32'd150);
    bus.bridge_readdatavalid = 1'b1;
    bus.bridge_readdata      = 16'h3096;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 0, 1'b0, 1'b1);
    chk("async_rst_pixel", 32'(bus.pixel_data), 32'h0);
    chk("async_rst_unf", 32'(bus.underflow), 32'h0);
    @(negedge clk);
    bus.bridge_readdatavalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0);
    chk_state("post_rst_wr", 1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h7777);
    @(negedge clk);
    chk_state("post_rst_rd", 0, 1'b0, 1'b1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
